// File: rtl/riscv_ahb_arbiter.sv
// Two-master AHB-Lite arbiter: fetch (if_code) and load/store (ldst) share one slave bus.
// Fixed ldst priority with a fetch starvation guard; one-entry hold register per master.
module riscv_ahb_arbiter #(
    parameter int unsigned MAX_LDST_RUN = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] if_code_haddr_i,
    input  logic [1:0]  if_code_htrans_i,
    input  logic        if_code_hwrite_i,
    input  logic [2:0]  if_code_hsize_i,
    input  logic [2:0]  if_code_hburst_i,
    input  logic [3:0]  if_code_hprot_i,
    input  logic        if_code_hmastlock_i,
    output logic        if_code_hready_o,
    output logic        if_code_hresp_o,
    output logic [31:0] if_code_hrdata_o,
    input  logic [31:0] ldst_haddr_i,
    input  logic [1:0]  ldst_htrans_i,
    input  logic        ldst_hwrite_i,
    input  logic [2:0]  ldst_hsize_i,
    input  logic [2:0]  ldst_hburst_i,
    input  logic [3:0]  ldst_hprot_i,
    input  logic        ldst_hmastlock_i,
    input  logic [31:0] ldst_hwdata_i,
    output logic        ldst_hready_o,
    output logic        ldst_hresp_o,
    output logic [31:0] ldst_hrdata_o,
    output logic [31:0] s_haddr_o,
    output logic [1:0]  s_htrans_o,
    output logic        s_hwrite_o,
    output logic [2:0]  s_hsize_o,
    output logic [2:0]  s_hburst_o,
    output logic [3:0]  s_hprot_o,
    output logic        s_hmastlock_o,
    output logic [31:0] s_hwdata_o,
    input  logic        s_hready_i,
    input  logic        s_hresp_i,
    input  logic [31:0] s_hrdata_i
);

    localparam int unsigned CntW = $clog2(MAX_LDST_RUN + 1);
    localparam logic [CntW-1:0] MaxRun = CntW'(MAX_LDST_RUN);

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        mastlock;
    } req_t;

    typedef enum logic [1:0] {StIdle, StPend, StData} mst_st_e;
    typedef enum logic [1:0] {SelNone, SelFetch, SelLdst} sel_e;

    req_t            f_live, l_live, f_req, l_req, s_req;
    req_t            f_hold_q, f_hold_d, l_hold_q, l_hold_d;
    mst_st_e         f_st_q, f_st_d, l_st_q, l_st_d;
    sel_e            sel_q, sel_d, grant, s_sel;
    logic [CntW-1:0] starve_q, starve_d;
    logic            f_live_v, l_live_v, f_pres, l_pres, f_keep, l_keep;

    assign f_live = {if_code_haddr_i, if_code_htrans_i, if_code_hwrite_i, if_code_hsize_i,
                     if_code_hburst_i, if_code_hprot_i, if_code_hmastlock_i};
    assign l_live = {ldst_haddr_i, ldst_htrans_i, ldst_hwrite_i, ldst_hsize_i,
                     ldst_hburst_i, ldst_hprot_i, ldst_hmastlock_i};

    assign if_code_hready_o = (f_st_q == StIdle) | ((f_st_q == StData) & s_hready_i);
    assign ldst_hready_o    = (l_st_q == StIdle) | ((l_st_q == StData) & s_hready_i);
    assign if_code_hresp_o  = (f_st_q == StData) & s_hresp_i;
    assign ldst_hresp_o     = (l_st_q == StData) & s_hresp_i;
    assign if_code_hrdata_o = s_hrdata_i;
    assign ldst_hrdata_o    = s_hrdata_i;
    assign s_hwdata_o       = (l_st_q == StData) ? ldst_hwdata_i : '0;

    assign f_live_v = f_live.trans[1] & if_code_hready_o;
    assign l_live_v = l_live.trans[1] & ldst_hready_o;
    assign f_pres   = f_live_v | (f_st_q == StPend);
    assign l_pres   = l_live_v | (l_st_q == StPend);
    assign f_req    = (f_st_q == StPend) ? f_hold_q : f_live;
    assign l_req    = (l_st_q == StPend) ? l_hold_q : l_live;
    // The current owner keeps the bus for SEQ beats and locked sequences.
    assign f_keep   = (sel_q == SelFetch) & f_pres & ((f_req.trans == 2'b11) | f_req.mastlock);
    assign l_keep   = (sel_q == SelLdst) & l_pres & ((l_req.trans == 2'b11) | l_req.mastlock);

    always_comb begin
        grant = SelNone;
        if (rst_ni && s_hready_i) begin
            if (l_keep)                         grant = SelLdst;
            else if (f_keep)                    grant = SelFetch;
            else if (f_pres && starve_q == MaxRun) grant = SelFetch;
            else if (l_pres)                    grant = SelLdst;
            else if (f_pres)                    grant = SelFetch;
        end
    end

    // While the slave stalls, keep presenting the last owner's view of the bus.
    assign s_sel = s_hready_i ? grant : sel_q;

    always_comb begin
        s_req = '0;
        case (s_sel)
            SelFetch: s_req = f_req;
            SelLdst:  s_req = l_req;
            default:  s_req = '0;
        endcase
    end

    assign {s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o,
            s_hmastlock_o} = s_req;

    always_comb begin
        f_st_d   = f_st_q;
        l_st_d   = l_st_q;
        f_hold_d = f_hold_q;
        l_hold_d = l_hold_q;
        sel_d    = s_hready_i ? grant : sel_q;
        starve_d = starve_q;

        if (grant == SelFetch) begin
            f_st_d   = StData;
            f_hold_d = '0;
        end else if (f_live_v) begin
            f_st_d   = StPend;
            f_hold_d = f_live;
        end else if (s_hready_i && f_st_q == StData) begin
            f_st_d   = StIdle;
        end

        if (grant == SelLdst) begin
            l_st_d   = StData;
            l_hold_d = '0;
        end else if (l_live_v) begin
            l_st_d   = StPend;
            l_hold_d = l_live;
        end else if (s_hready_i && l_st_q == StData) begin
            l_st_d   = StIdle;
        end

        if (!f_pres || grant == SelFetch) begin
            starve_d = '0;
        end else if (grant == SelLdst && starve_q != MaxRun) begin
            starve_d = starve_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_st_q   <= StIdle;
            l_st_q   <= StIdle;
            f_hold_q <= '0;
            l_hold_q <= '0;
            sel_q    <= SelNone;
            starve_q <= '0;
        end else begin
            f_st_q   <= f_st_d;
            l_st_q   <= l_st_d;
            f_hold_q <= f_hold_d;
            l_hold_q <= l_hold_d;
            sel_q    <= sel_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_riscv_ahb_arbiter.sv
// Directed bench for riscv_ahb_arbiter: masters are driven cycle by cycle and the shared bus
// and per-master responses are compared with hand-derived values.
module tb_riscv_ahb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] f_haddr, l_haddr, l_hwdata;
    logic [1:0]  f_htrans, l_htrans;
    logic        f_hwrite, l_hwrite, f_hmastlock, l_hmastlock;
    logic [2:0]  f_hsize, l_hsize, f_hburst, l_hburst;
    logic [3:0]  f_hprot, l_hprot;
    logic        f_hready, f_hresp, l_hready, l_hresp;
    logic [31:0] f_hrdata, l_hrdata;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [1:0]  s_htrans;
    logic        s_hwrite, s_hmastlock, s_hready, s_hresp;
    logic [2:0]  s_hsize, s_hburst;
    logic [3:0]  s_hprot;

    int n_pass = 0;
    int n_total = 0;

    // Ldst master program for run_seq; fetch issues one NONSEQ at seq_faddr in cycle 0.
    logic [31:0] seq_laddr[8];
    logic [1:0]  seq_ltrans[8];
    logic        seq_llock[8];
    logic [2:0]  seq_lburst;
    logic [31:0] seq_faddr;
    logic [31:0] seq_exp[8];

    riscv_ahb_arbiter #(.MAX_LDST_RUN(4)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .if_code_haddr_i    (f_haddr),
        .if_code_htrans_i   (f_htrans),
        .if_code_hwrite_i   (f_hwrite),
        .if_code_hsize_i    (f_hsize),
        .if_code_hburst_i   (f_hburst),
        .if_code_hprot_i    (f_hprot),
        .if_code_hmastlock_i(f_hmastlock),
        .if_code_hready_o   (f_hready),
        .if_code_hresp_o    (f_hresp),
        .if_code_hrdata_o   (f_hrdata),
        .ldst_haddr_i       (l_haddr),
        .ldst_htrans_i      (l_htrans),
        .ldst_hwrite_i      (l_hwrite),
        .ldst_hsize_i       (l_hsize),
        .ldst_hburst_i      (l_hburst),
        .ldst_hprot_i       (l_hprot),
        .ldst_hmastlock_i   (l_hmastlock),
        .ldst_hwdata_i      (l_hwdata),
        .ldst_hready_o      (l_hready),
        .ldst_hresp_o       (l_hresp),
        .ldst_hrdata_o      (l_hrdata),
        .s_haddr_o          (s_haddr),
        .s_htrans_o         (s_htrans),
        .s_hwrite_o         (s_hwrite),
        .s_hsize_o          (s_hsize),
        .s_hburst_o         (s_hburst),
        .s_hprot_o          (s_hprot),
        .s_hmastlock_o      (s_hmastlock),
        .s_hwdata_o         (s_hwdata),
        .s_hready_i         (s_hready),
        .s_hresp_i          (s_hresp),
        .s_hrdata_i         (s_hrdata)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv_f(input logic [1:0] t, input logic [31:0] a);
        f_htrans = t; f_haddr = a; f_hwrite = 1'b0; f_hsize = 3'd2;
        f_hburst = 3'd0; f_hprot = 4'h1; f_hmastlock = 1'b0;
    endtask

    task automatic drv_l(input logic [1:0] t, input logic [31:0] a, input logic w,
                         input logic [2:0] b, input logic lk);
        l_htrans = t; l_haddr = a; l_hwrite = w; l_hsize = 3'd2;
        l_hburst = b; l_hprot = 4'h3; l_hmastlock = lk;
    endtask

    task automatic idle_all();
        drv_f(2'b00, 32'h0);
        drv_l(2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
    endtask

    // Masters advance to their next transfer only after an edge with their HREADY high.
    task automatic run_seq(input string nm, input int n_l, input int n_cyc);
        int  li = 0;
        bit  fdone = 0;
        logic lrdy, frdy;
        for (int c = 0; c < n_cyc; c++) begin
            if (fdone) drv_f(2'b00, 32'h0);
            else       drv_f(2'b10, seq_faddr);
            if (li < n_l) drv_l(seq_ltrans[li], seq_laddr[li], 1'b0, seq_lburst, seq_llock[li]);
            else          drv_l(2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
            #2;
            check($sformatf("%s_c%0d_haddr", nm, c), s_haddr, seq_exp[c]);
            lrdy = l_hready;
            frdy = f_hready;
            tick();
            if (lrdy && li < n_l) li++;
            if (frdy) fdone = 1;
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic t1_fetch_alone(input string nm);
        drv_f(2'b10, 32'h1000);
        #2;
        check({nm, "_haddr"}, s_haddr, 32'h1000);
        check({nm, "_htrans"}, {30'd0, s_htrans}, 32'd2);
        tick();
        drv_f(2'b00, 32'h0);
        s_hrdata = 32'hDEAD_BEEF;
        #2;
        check({nm, "_f_hready"}, {31'd0, f_hready}, 32'd1);
        check({nm, "_f_hrdata"}, f_hrdata, 32'hDEAD_BEEF);
        check({nm, "_idle"}, {30'd0, s_htrans}, 32'd0);
        tick();
        tick();
    endtask

    initial begin
        rst_ni = 1'b0;
        s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0; l_hwdata = 32'h0;
        idle_all();
        #2;
        // Live requests during reset must not reach the slave.
        drv_f(2'b10, 32'h1000);
        drv_l(2'b10, 32'h2000, 1'b1, 3'd0, 1'b0);
        #1;
        check("rst_htrans", {30'd0, s_htrans}, 32'd0);
        check("rst_haddr", s_haddr, 32'd0);
        check("rst_f_hready", {31'd0, f_hready}, 32'd1);
        check("rst_l_hready", {31'd0, l_hready}, 32'd1);
        idle_all();
        tick();
        rst_ni = 1'b1;
        tick();

        t1_fetch_alone("t1");

        // T2: simultaneous ldst write and fetch
        drv_l(2'b10, 32'h2000, 1'b1, 3'd0, 1'b0);
        drv_f(2'b10, 32'h1004);
        #2;
        check("t2_c0_haddr", s_haddr, 32'h2000);
        check("t2_c0_hwrite", {31'd0, s_hwrite}, 32'd1);
        tick();
        drv_l(2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        drv_f(2'b00, 32'h0);
        l_hwdata = 32'hA5A5_0001;
        s_hresp = 1'b1;
        #2;
        check("t2_c1_haddr", s_haddr, 32'h1004);
        check("t2_c1_f_hready", {31'd0, f_hready}, 32'd0);
        check("t2_c1_hwdata", s_hwdata, 32'hA5A5_0001);
        check("t2_c1_l_hresp", {31'd0, l_hresp}, 32'd1);
        check("t2_c1_f_hresp", {31'd0, f_hresp}, 32'd0);
        tick();
        s_hresp = 1'b0;
        #2;
        check("t2_c2_f_hready", {31'd0, f_hready}, 32'd1);
        check("t2_c2_hwdata", s_hwdata, 32'h0);
        tick();
        tick();

        // T3: ldst stream vs waiting fetch; fetch forced in after four ldst grants
        for (int i = 0; i < 8; i++) begin
            seq_laddr[i] = 32'h3000 + 32'(4 * i); seq_ltrans[i] = 2'b10; seq_llock[i] = 1'b0;
        end
        seq_lburst = 3'd0; seq_faddr = 32'h1100;
        seq_exp[0] = 32'h3000; seq_exp[1] = 32'h3004; seq_exp[2] = 32'h3008;
        seq_exp[3] = 32'h300C; seq_exp[4] = 32'h1100; seq_exp[5] = 32'h3010;
        seq_exp[6] = 32'h3014; seq_exp[7] = 32'h0;
        run_seq("t3", 6, 8);

        // T4: slave wait states during ldst data phase with fetch held
        drv_l(2'b10, 32'h4000, 1'b1, 3'd0, 1'b0);
        drv_f(2'b10, 32'h1200);
        #2;
        check("t4_c0_haddr", s_haddr, 32'h4000);
        tick();
        drv_l(2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        drv_f(2'b00, 32'h0);
        l_hwdata = 32'h4444_4444;
        s_hready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #2;
            check($sformatf("t4_w%0d_htrans", c), {30'd0, s_htrans}, 32'd0);
            check($sformatf("t4_w%0d_f_hready", c), {31'd0, f_hready}, 32'd0);
            check($sformatf("t4_w%0d_l_hready", c), {31'd0, l_hready}, 32'd0);
            check($sformatf("t4_w%0d_hwdata", c), s_hwdata, 32'h4444_4444);
            tick();
        end
        s_hready = 1'b1;
        #2;
        check("t4_c4_haddr", s_haddr, 32'h1200);
        check("t4_c4_htrans", {30'd0, s_htrans}, 32'd2);
        tick();
        #2;
        check("t4_c5_f_hready", {31'd0, f_hready}, 32'd1);
        tick();
        tick();

        // T5a: INCR4 started with the starvation count already at one
        seq_laddr[0] = 32'h5FF0; seq_ltrans[0] = 2'b10;
        seq_laddr[1] = 32'h5000; seq_ltrans[1] = 2'b10;
        seq_laddr[2] = 32'h5004; seq_ltrans[2] = 2'b11;
        seq_laddr[3] = 32'h5008; seq_ltrans[3] = 2'b11;
        seq_laddr[4] = 32'h500C; seq_ltrans[4] = 2'b11;
        for (int i = 0; i < 8; i++) seq_llock[i] = 1'b0;
        seq_lburst = 3'b011; seq_faddr = 32'h1300;
        seq_exp[0] = 32'h5FF0; seq_exp[1] = 32'h5000; seq_exp[2] = 32'h5004;
        seq_exp[3] = 32'h5008; seq_exp[4] = 32'h500C; seq_exp[5] = 32'h1300;
        seq_exp[6] = 32'h0; seq_exp[7] = 32'h0;
        run_seq("t5a", 5, 7);

        // T5b: locked NONSEQ sequence behaves like a burst
        for (int i = 1; i < 5; i++) begin
            seq_laddr[i] = 32'h6000 + 32'(4 * (i - 1)); seq_ltrans[i] = 2'b10; seq_llock[i] = 1'b1;
        end
        seq_lburst = 3'd0;
        seq_exp[1] = 32'h6000; seq_exp[2] = 32'h6004; seq_exp[3] = 32'h6008;
        seq_exp[4] = 32'h600C;
        run_seq("t5b", 5, 7);

        // T6: asynchronous reset with fetch held and ldst in data phase
        drv_l(2'b10, 32'h7000, 1'b0, 3'd0, 1'b0);
        drv_f(2'b10, 32'h1400);
        tick();
        drv_l(2'b10, 32'h7004, 1'b0, 3'd0, 1'b0);
        drv_f(2'b00, 32'h0);
        s_hresp = 1'b1;
        #2;
        check("t6_pre_f_hready", {31'd0, f_hready}, 32'd0);
        rst_ni = 1'b0;
        #1;
        check("t6_htrans", {30'd0, s_htrans}, 32'd0);
        check("t6_haddr", s_haddr, 32'd0);
        check("t6_f_hready", {31'd0, f_hready}, 32'd1);
        check("t6_l_hready", {31'd0, l_hready}, 32'd1);
        check("t6_l_hresp", {31'd0, l_hresp}, 32'd0);
        s_hresp = 1'b0;
        idle_all();
        tick();
        rst_ni = 1'b1;
        tick();
        t1_fetch_alone("t6_t1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
